// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if -- bundle of requester handshakes, operand buses and the FPU
// side connection for fpu_arbiter.
//
//   req0/req1            level requests, held until the matching done pulse
//   opA0/opB0/opA1/opB1  operands per requester, stable while req is high
//   ack0/ack1            one-cycle grant pulses
//   done0/done1          one-cycle completion pulses
//   result_out/status    captured FPU data and status, held between captures
//   busy                 arbiter is in any state other than IDLE
//   fpu_op_A/fpu_op_B    operands presented to the FPU
//   fpu_data_in/status   FPU outputs sampled by the arbiter
//
// slave  : the arbiter's view
// master : the view of whatever drives requests and models the FPU
interface fpu_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] opA0;
    logic [31:0] opB0;
    logic [31:0] opA1;
    logic [31:0] opB1;
    logic        ack0;
    logic        ack1;
    logic        done0;
    logic        done1;
    logic [31:0] result_out;
    logic [3:0]  result_status;
    logic        busy;
    logic [31:0] fpu_op_A;
    logic [31:0] fpu_op_B;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;

    modport slave (
        input  req0, req1, opA0, opB0, opA1, opB1, fpu_data_in, fpu_status_in,
        output ack0, ack1, done0, done1, result_out, result_status, busy,
               fpu_op_A, fpu_op_B
    );

    modport master (
        output req0, req1, opA0, opB0, opA1, opB1, fpu_data_in, fpu_status_in,
        input  ack0, ack1, done0, done1, result_out, result_status, busy,
               fpu_op_A, fpu_op_B
    );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter -- shares one FPU between two requesters.
//
// A winner is picked round-robin in IDLE, its operands are latched and held on
// the FPU for WAIT_CYCLES cycles, then the FPU data/status are captured and the
// owner gets a done pulse. No arithmetic happens here; data passes through.
//
// Ports:
//   clock100KHz  sole clock, rising edge
//   reset        asynchronous, active-low
//   bus          fpu_arbiter_if.slave (requests, operands, grants, results, FPU)
//
// Parameter:
//   WAIT_CYCLES  8..255, cycles operands sit on the FPU before capture; must
//                cover two full FPU passes because status lags data by a pass.
module fpu_arbiter #(
    parameter int WAIT_CYCLES = 80
) (
    input  logic         clock100KHz,
    input  logic         reset,
    fpu_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [1:0]        req;
    logic [1:0][31:0]  op_a_in, op_b_in;
    logic              winner;
    logic              owner;
    logic              last_grant;
    logic [7:0]        wait_cnt;
    logic [31:0]       op_a_q, op_b_q;
    logic [31:0]       result_q;
    logic [3:0]        status_q;
    logic [1:0]        ack, done;
    logic              busy;

    assign req     = {bus.req1, bus.req0};
    assign op_a_in = {bus.opA1, bus.opA0};
    assign op_b_in = {bus.opB1, bus.opB0};

    // Single request wins outright; on a tie the side not granted last wins.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) winner = ~last_grant;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // ack is raised in the IDLE cycle that makes the grant, so the requester
    // sees it in the same cycle the arbiter commits to LOAD. It is gated by
    // reset because state sits in IDLE while reset is held and req may be high.
    always_comb begin
        ack  = '0;
        done = '0;
        busy = (state != IDLE);
        if (state == IDLE && reset && (|req)) ack[winner] = 1'b1;
        if (state == DONE)                   done[owner] = 1'b1;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            result_q   <= 32'd0;
            status_q   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) owner <= winner;
                end
                LOAD: begin
                    // Only place the FPU operands change; held through
                    // WAIT and CAPTURE regardless of requester-side churn.
                    op_a_q   <= op_a_in[owner];
                    op_b_q   <= op_b_in[owner];
                    wait_cnt <= 8'd0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                CAPTURE: begin
                    result_q <= bus.fpu_data_in;
                    status_q <= bus.fpu_status_in;
                end
                DONE: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack0          = ack[0];
    assign bus.ack1          = ack[1];
    assign bus.done0         = done[0];
    assign bus.done1         = done[1];
    assign bus.busy          = busy;
    assign bus.fpu_op_A      = op_a_q;
    assign bus.fpu_op_B      = op_b_q;
    assign bus.result_out    = result_q;
    assign bus.result_status = status_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
`timescale 1ns/1ps
module tb_fpu_arbiter;
    localparam int WC  = 80;
    localparam int LAT = WC + 3;   // ack cycle to done cycle

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fpu_arbiter_if bus();

    fpu_arbiter #(.WAIT_CYCLES(WC)) dut (
        .clock100KHz(clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5000 clk = ~clk;

    typedef struct {
        logic        who;
        logic [31:0] res;
        logic [3:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ack_cnt  = 0;
    int   done_cnt = 0;
    int   ack_cyc  = 0;
    int   done_cyc = 0;
    logic ack_who  = 1'b0;

    // Stand-in FPU: data has two cycles of latency, status one more.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
        return a ^ b ^ 32'h4200_0000;
    endfunction

    function automatic logic [3:0] st_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == b)            return 4'b0001;
        else if (a[31] ^ b[31]) return 4'b0100;
        else                   return 4'b0010;
    endfunction

    function automatic exp_t mk(input logic who, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.who = who;
        e.res = fpu_fn(a, b);
        e.st  = st_fn(a, b);
        return e;
    endfunction

    logic [31:0] d1;
    logic [3:0]  s1, s2;
    always @(posedge clk) begin
        d1                <= fpu_fn(bus.fpu_op_A, bus.fpu_op_B);
        bus.fpu_data_in   <= d1;
        s1                <= st_fn(bus.fpu_op_A, bus.fpu_op_B);
        s2                <= s1;
        bus.fpu_status_in <= s2;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant/done monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (bus.ack0 || bus.ack1) begin
            check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
            ack_cyc = cyc;
            ack_who = bus.ack1;
            ack_cnt++;
        end
        if (bus.done0 || bus.done1) begin
            exp_t e;
            check("done_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done_who", 32'(bus.done1), 32'(e.who));
                check("done_vs_ack_owner", 32'(bus.done1), 32'(ack_who));
                check("grant_to_done", 32'(cyc - ack_cyc), 32'(LAT));
                check("result_out", bus.result_out, e.res);
                check("result_status", 32'(bus.result_status), 32'(e.st));
            end
            done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic wait_ack(input int target);
        int n = 0;
        while (ack_cnt < target && n < 2 * LAT + 10) begin
            @(negedge clk); #1; n++;
        end
        check("wait_ack", 32'(ack_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 2 * LAT + 10) begin
            @(negedge clk); #1; n++;
        end
        check("wait_done", 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        int d0;
        int a;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.opA0 = '0; bus.opB0 = '0; bus.opA1 = '0; bus.opB1 = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_handshake", 32'({bus.ack1, bus.ack0, bus.done1, bus.done0, bus.busy}), 32'd0);
        check("rst_result", bus.result_out, 32'd0);
        check("rst_status", 32'(bus.result_status), 32'd0);
        check("rst_op_a", bus.fpu_op_A, 32'd0);
        check("rst_op_b", bus.fpu_op_B, 32'd0);
        reset = 1'b1;

        // simultaneous requests after reset: 0 first, 1 right after
        @(posedge clk); #1;
        bus.opA0 = 32'h3f80_0000; bus.opB0 = 32'h4040_0000;
        bus.opA1 = 32'hc000_0000; bus.opB1 = 32'h40a0_0000;
        exp_q.push_back(mk(1'b0, bus.opA0, bus.opB0));
        exp_q.push_back(mk(1'b1, bus.opA1, bus.opB1));
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(1);
        check("tie_first_owner", 32'(ack_who), 32'd0);
        wait_done(1);
        bus.req0 = 1'b0;
        d0 = done_cyc;
        wait_ack(2);
        check("tie_second_owner", 32'(ack_who), 32'd1);
        check("tie_gap", 32'(ack_cyc - d0), 32'd1);
        wait_done(2);
        bus.req1 = 1'b0;

        // single request, reference operands
        @(posedge clk); #1;
        bus.opA0 = 32'h4000_0000; bus.opB0 = 32'h4000_0000;
        exp_q.push_back('{who: 1'b0, res: 32'h4200_0000, st: 4'b0001});
        bus.req0 = 1'b1;
        wait_ack(3);
        check("single_owner", 32'(ack_who), 32'd0);
        wait_done(3);
        bus.req0 = 1'b0;

        // both held: last served was 0, so 1,0,1,0,1,0
        @(posedge clk); #1;
        bus.opA0 = 32'h4120_0000; bus.opB0 = 32'h3f00_0000;
        bus.opA1 = 32'hc120_0000; bus.opB1 = 32'h4120_0000;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_q.push_back(mk(1'b1, bus.opA1, bus.opB1));
            else            exp_q.push_back(mk(1'b0, bus.opA0, bus.opB0));
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 6; k++) wait_done(4 + k);
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // operands change during WAIT
        @(posedge clk); #1;
        bus.opA0 = 32'h4120_0000; bus.opB0 = 32'h3e80_0000;
        exp_q.push_back(mk(1'b0, 32'h4120_0000, 32'h3e80_0000));
        bus.req0 = 1'b1;
        wait_ack(10);
        repeat (10) @(negedge clk); #1;
        check("op_a_latched", bus.fpu_op_A, 32'h4120_0000);
        bus.opA0 = 32'hdead_beef; bus.opB0 = 32'h1234_5678;
        repeat (20) @(negedge clk); #1;
        check("op_a_stable", bus.fpu_op_A, 32'h4120_0000);
        check("op_b_stable", bus.fpu_op_B, 32'h3e80_0000);
        wait_done(10);
        bus.req0 = 1'b0;

        // reset in WAIT: abort, no done, re-serviced after release
        @(posedge clk); #1;
        bus.opA1 = 32'h4049_0fdb; bus.opB1 = 32'h402d_f854;
        bus.req1 = 1'b1;
        wait_ack(11);
        repeat (20) @(negedge clk); #1;
        check("busy_in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_op_a", bus.fpu_op_A, 32'd0);
        check("abort_op_b", bus.fpu_op_B, 32'd0);
        check("abort_result", bus.result_out, 32'd0);
        check("abort_status", 32'(bus.result_status), 32'd0);
        repeat (3) @(negedge clk); #1;
        check("abort_no_ack", 32'({bus.ack1, bus.ack0, bus.done1, bus.done0}), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd10);
        exp_q.push_back(mk(1'b1, bus.opA1, bus.opB1));
        @(posedge clk); #1;
        reset = 1'b1;
        wait_ack(12);
        check("post_reset_owner", 32'(ack_who), 32'd1);
        wait_done(11);
        bus.req1 = 1'b0;

        // req1 dropped one cycle after ack1
        @(posedge clk); #1;
        bus.opA1 = 32'h3f00_0000; bus.opB1 = 32'hbf00_0000;
        exp_q.push_back(mk(1'b1, bus.opA1, bus.opB1));
        bus.req1 = 1'b1;
        wait_ack(13);
        a = ack_cyc;
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        wait_done(12);
        check("drop_done_latency", 32'(done_cyc - a), 32'(LAT));
        check("busy_in_done", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        check("busy_after_done", 32'(bus.busy), 32'd0);

        repeat (5) @(negedge clk); #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("idle_at_end", 32'({bus.busy, bus.ack1, bus.ack0}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
